// File: rtl/dsp_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// Define DSP_DIVIDER_EARLY_OUT_EN to skip the iteration loop for divide-by-zero and signed overflow.
module dsp_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    state_t            state_r;
    logic              op_rem_r;
    logic              q_neg_r;
    logic              r_neg_r;
    logic              div_zero_r;
    logic              ovf_r;
    logic              fix_phase_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  rem_r;
    logic [WIDTH-1:0]  quo_r;
    logic [WIDTH-1:0]  dvsr_r;
    logic [WIDTH-1:0]  dividend_raw_r;
    logic [WIDTH-1:0]  result_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic              signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic [WIDTH-1:0]  shift_s;
    logic [WIDTH:0]    trial_s;
    logic [WIDTH-1:0]  rem_next_s;
    logic              quo_bit_s;
    logic [WIDTH-1:0]  fix_val_s;

    // Operand decode at accept: signs, magnitudes and special-case detection.
    always_comb begin
        signed_s   = ~op[0];
        a_neg_s    = signed_s & dividend[WIDTH-1];
        b_neg_s    = signed_s & divisor[WIDTH-1];
        // The most negative value negates to itself, which is its correct unsigned magnitude.
        a_mag_s    = a_neg_s ? (ZERO_W - dividend) : dividend;
        b_mag_s    = b_neg_s ? (ZERO_W - divisor) : divisor;
        div_zero_s = (divisor == ZERO_W);
        ovf_s      = signed_s && (dividend == MIN_W) && (divisor == ONES_W);
    end

    // One restoring-division step: trial subtract of the divisor from the shifted remainder.
    always_comb begin
        shift_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
        trial_s = {1'b0, shift_s} - {1'b0, dvsr_r};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_bit_s  = 1'b1;
        end else begin
            rem_next_s = shift_s;
            quo_bit_s  = 1'b0;
        end
    end

    // Final result select, with divide-by-zero and overflow overriding the computed value.
    always_comb begin
        fix_val_s = ZERO_W;
        if (div_zero_r) begin
            fix_val_s = op_rem_r ? dividend_raw_r : ONES_W;
        end else if (ovf_r) begin
            fix_val_s = op_rem_r ? ZERO_W : dividend_raw_r;
        end else begin
            fix_val_s = op_rem_r ? rem_r : quo_r;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            op_rem_r       <= 1'b0;
            q_neg_r        <= 1'b0;
            r_neg_r        <= 1'b0;
            div_zero_r     <= 1'b0;
            ovf_r          <= 1'b0;
            fix_phase_r    <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            rem_r          <= ZERO_W;
            quo_r          <= ZERO_W;
            dvsr_r         <= ZERO_W;
            dividend_raw_r <= ZERO_W;
            result_r       <= ZERO_W;
            in_ready_r     <= 1'b1;
            out_valid_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        op_rem_r       <= op[1];
                        q_neg_r        <= a_neg_s ^ b_neg_s;
                        r_neg_r        <= a_neg_s;
                        div_zero_r     <= div_zero_s;
                        ovf_r          <= ovf_s;
                        dividend_raw_r <= dividend;
                        dvsr_r         <= b_mag_s;
                        rem_r          <= ZERO_W;
                        quo_r          <= a_mag_s;
                        cnt_r          <= CNT_INIT;
                        fix_phase_r    <= 1'b0;
                        in_ready_r     <= 1'b0;
                        busy_r         <= 1'b1;
`ifdef DSP_DIVIDER_EARLY_OUT_EN
                        state_r        <= (div_zero_s || ovf_s) ? FIXUP : CALC;
`else
                        state_r        <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[WIDTH-2:0], quo_bit_s};
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= FIXUP;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIXUP: begin
                    // Sign correction is registered first so the negate adders stay off the result mux path.
                    if (!fix_phase_r) begin
                        quo_r       <= q_neg_r ? (ZERO_W - quo_r) : quo_r;
                        rem_r       <= r_neg_r ? (ZERO_W - rem_r) : rem_r;
                        fix_phase_r <= 1'b1;
                    end else begin
                        result_r    <= fix_val_s;
                        out_valid_r <= 1'b1;
                        fix_phase_r <= 1'b0;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dsp_divider.sv
// Self-checking bench for dsp_divider: directed vector table, handshake/reset sequences
// and randomized operations compared against an arithmetic reference model.
module tb_dsp_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_tests;
    int n_fail;

    dsp_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) r = o[1] ? a : 32'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = o[1] ? 32'd0 : a;
        else if (o[0]) r = o[1] ? (a % b) : (a / b);
        else r = o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int l;
        l = 34;
`ifdef DSP_DIVIDER_EARLY_OUT_EN
        if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) l = 2;
`endif
        return l;
    endfunction

    // Issue one request, scramble inputs while it runs, wait (bounded) for out_valid.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            op = 2'($urandom); dividend = $urandom; divisor = $urandom;
            @(posedge clk);
            lat++;
            #1;
        end
        res = result;
    endtask

    vec_t        vecs[$];
    logic [31:0] res;
    logic [31:0] held;
    int          lat;
    int          hits;

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0; out_ready = 1'b1;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2});
        vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2});
        vecs.push_back('{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE});
        vecs.push_back('{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678});
        vecs.push_back('{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3});

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset result",    result,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].a, vecs[i].b)));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d idle", i), {30'd0, in_ready, out_valid}, 32'd2);
        end

        // Backpressure: result held while out_ready stays low, requests ignored.
        out_ready = 1'b0;
        run_op(2'b01, 32'd1000, 32'd9, res, lat);
        check("bp result", res, 32'd111);
        held = res;
        in_valid = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp hold", {29'd0, out_valid, in_ready, busy}, 32'd5);
            check("bp stable", result, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release", {29'd0, out_valid, in_ready, busy}, 32'd2);

        // Mid-operation reset abandons the request.
        @(negedge clk);
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst outputs", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("mid rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        check("no out_valid after rst", 32'(hits), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, res, lat);
        check("post rst result", res, 32'd3);
        check("post rst latency", 32'(lat), 32'd34);
        @(posedge clk);
        #1;

        // Randomized operations against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(1, 17));
                1: rb = 32'd0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 40));
                4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(ro, ra, rb, res, lat);
            check($sformatf("rand%0d op%0d %h/%h", n, ro, ra, rb), res, model(ro, ra, rb));
            check($sformatf("rand%0d latency", n), 32'(lat), 32'(exp_lat(ro, ra, rb)));
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
